// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: sums the enabled voices of an oscillator bank into one frame.
// Optional sticky overrun flag is compiled in with VOICE_MIXER_OVERRUN_DET_EN.
module voice_mixer #(
    parameter int NUM_OSCILLATORS         = 8,
    parameter int SAMPLE_WIDTH            = 8,
    parameter int PRE_DIVISION_AUDIO_SIZE = 16,
    localparam int SEL_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               sample_tick_in,
    input  logic [NUM_OSCILLATORS-1:0]         osc_enable_in,
    output logic [SEL_W-1:0]                   osc_sel_out,
    input  logic [SAMPLE_WIDTH-1:0]            osc_sample_in,
    output logic [PRE_DIVISION_AUDIO_SIZE-1:0] stream_out,
    output logic [NUM_OSCILLATORS-1:0]         is_on,
    output logic                               has_updated,
    output logic                               busy_out,
`ifdef VOICE_MIXER_OVERRUN_DET_EN
    output logic                               overrun_out,
`endif
    output logic [1:0]                         state_dbg_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [SEL_W-1:0]                     sel_q, sel_d;
    logic [NUM_OSCILLATORS-1:0]           snap_q, snap_d;
    logic [PRE_DIVISION_AUDIO_SIZE-1:0]   acc_q, acc_d;
    logic                                 rd_valid_q, rd_valid_d;
    logic [SEL_W-1:0]                     rd_idx_q, rd_idx_d;
    logic [PRE_DIVISION_AUDIO_SIZE-1:0]   stream_q, stream_d;
    logic [NUM_OSCILLATORS-1:0]           on_q, on_d;
    logic                                 upd_q, upd_d;

    // rd_valid/rd_idx remember which voice was addressed last cycle, matching
    // the bank's one-cycle read latency.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        snap_d     = snap_q;
        acc_d      = acc_q;
        rd_valid_d = 1'b0;
        rd_idx_d   = sel_q;
        stream_d   = stream_q;
        on_d       = on_q;
        upd_d      = 1'b0;

        if (rd_valid_q && snap_q[rd_idx_q]) begin
            acc_d = acc_q + PRE_DIVISION_AUDIO_SIZE'(osc_sample_in);
        end

        case (state_q)
            IDLE: begin
                if (sample_tick_in) begin
                    snap_d  = osc_enable_in;
                    acc_d   = '0;
                    sel_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                rd_valid_d = 1'b1;
                if (sel_q == SEL_W'(NUM_OSCILLATORS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                stream_d = acc_q;
                on_d     = snap_q;
                upd_d    = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            snap_q     <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            stream_q   <= '0;
            on_q       <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            snap_q     <= snap_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            stream_q   <= stream_d;
            on_q       <= on_d;
            upd_q      <= upd_d;
        end
    end

`ifdef VOICE_MIXER_OVERRUN_DET_EN
    logic overrun_q, overrun_d;

    // A tick that lands while a frame is in flight is dropped; remember that it happened.
    always_comb begin
        overrun_d = overrun_q | (sample_tick_in && (state_q != IDLE));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_out = overrun_q;
`endif

    assign osc_sel_out   = sel_q;
    assign stream_out    = stream_q;
    assign is_on         = on_q;
    assign has_updated   = upd_q;
    assign busy_out      = (state_q != IDLE);
    assign state_dbg_out = state_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Randomized scoreboard bench for voice_mixer: the expected frame sum, enable mask and
// update cycle are pushed per accepted tick; a negedge monitor pops and compares.
module tb_voice_mixer;

    localparam int N     = 8;
    localparam int SW    = 8;
    localparam int PRE   = 16;
    localparam int SEL_W = 3;
    localparam int W     = PRE + N;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic [N-1:0]      en;
    logic [SEL_W-1:0]  sel;
    logic [SW-1:0]     sample;
    logic [PRE-1:0]    stream;
    logic [N-1:0]      is_on;
    logic              upd;
    logic              busy;
    logic [1:0]        state_dbg;
`ifdef VOICE_MIXER_OVERRUN_DET_EN
    logic              overrun;
`endif

    voice_mixer #(
        .NUM_OSCILLATORS(N),
        .SAMPLE_WIDTH(SW),
        .PRE_DIVISION_AUDIO_SIZE(PRE)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .sample_tick_in(tick),
        .osc_enable_in(en),
        .osc_sel_out(sel),
        .osc_sample_in(sample),
        .stream_out(stream),
        .is_on(is_on),
        .has_updated(upd),
        .busy_out(busy),
`ifdef VOICE_MIXER_OVERRUN_DET_EN
        .overrun_out(overrun),
`endif
        .state_dbg_out(state_dbg)
    );

    // ---------------- clock / sample bank ----------------
    always #5 clk = ~clk;

    logic [SW-1:0] bank [N];
    int cycle_cnt = 0;

    always @(posedge clk) begin
        sample    <= bank[sel];
        cycle_cnt <= cycle_cnt + 1;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]   exp_q[$];
    int             exp_cyc_q[$];
    int             vectors = 0;
    int             miscompares = 0;
    int             frame_start = 0;
    int             busy_end = 0;
    logic           exp_overrun = 1'b0;
    logic [PRE-1:0] held_stream = '0;
    logic [N-1:0]   held_on = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int model_mix(input logic [N-1:0] mask);
        int s = 0;
        for (int k = 0; k < N; k++) begin
            if (mask[k]) s += int'(bank[k]);
        end
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue_tick();
        int c;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        c = cycle_cnt;
        if (c - 1 >= busy_end) begin
            frame_start = c;
            busy_end    = c + N + 2;
            exp_q.push_back({en, PRE'(model_mix(en))});
            exp_cyc_q.push_back(c + N + 2);
        end else begin
            exp_overrun = 1'b1;
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || cycle_cnt <= busy_end) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 32'(k >= 200), 32'd0);
        if (k >= 200) begin
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stream"}, 32'(stream), 32'd0);
        check({tag, "_is_on"}, 32'(is_on), 32'd0);
        check({tag, "_upd"}, 32'(upd), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sel"}, 32'(sel), 32'd0);
    endtask

    task automatic reset_mid_frame();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        exp_cyc_q.delete();
        frame_start = 0;
        busy_end    = 0;
        held_stream = '0;
        held_on     = '0;
        exp_overrun = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        int c;
        logic [W-1:0] e;
        int ec;
        if (!rst) begin
            c = cycle_cnt;
            if (upd) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", 32'(upd), 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("stream_out", 32'(stream), 32'(e[PRE-1:0]));
                    check("is_on", 32'(is_on), 32'(e[W-1:PRE]));
                    check("update_cycle", 32'(c), 32'(ec));
                    held_stream = e[PRE-1:0];
                    held_on     = e[W-1:PRE];
                end
            end else begin
                check("hold_stream", 32'(stream), 32'(held_stream));
                check("hold_is_on", 32'(is_on), 32'(held_on));
            end
            check("busy_out", 32'(busy), 32'(c >= frame_start && c < busy_end));
            if (c >= frame_start && c < busy_end && c - frame_start <= N - 1) begin
                check("osc_sel", 32'(sel), 32'(c - frame_start));
            end
`ifdef VOICE_MIXER_OVERRUN_DET_EN
            check("overrun", 32'(overrun), 32'(exp_overrun));
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        en   = '0;
        for (int k = 0; k < N; k++) bank[k] = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // all voices at full scale
        for (int k = 0; k < N; k++) bank[k] = 8'd255;
        en = 8'hFF;
        issue_tick();
        wait_drain();

        // sparse mask with index-dependent samples
        for (int k = 0; k < N; k++) bank[k] = SW'(k * 10);
        en = 8'b0000_0101;
        issue_tick();
        wait_drain();

        // enable mask changes after snapshot must not leak in
        for (int k = 0; k < N; k++) bank[k] = 8'd1;
        en = 8'h0F;
        issue_tick();
        repeat (3) @(negedge clk);
        en = 8'h00;
        wait_drain();

        // second tick three cycles in is dropped
        for (int k = 0; k < N; k++) bank[k] = SW'($urandom_range(0, 255));
        en = 8'hA5;
        issue_tick();
        repeat (2) @(negedge clk);
        issue_tick();
        wait_drain();

        // reset in the middle of READ abandons the frame
        en = 8'hFF;
        issue_tick();
        reset_mid_frame();
        repeat (N + 4) @(negedge clk);
        for (int k = 0; k < N; k++) bank[k] = SW'($urandom_range(0, 255));
        en = 8'h3C;
        issue_tick();
        wait_drain();

        // empty mask still produces a frame
        en = 8'h00;
        issue_tick();
        wait_drain();

        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < N; k++) bank[k] = SW'($urandom_range(0, 255));
            en = N'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue_tick();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, N)) @(negedge clk);
                en = N'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, N + 2)) @(negedge clk);
                issue_tick();
            end
            wait_drain();
        end

        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
